// File: rtl/display_scan_ctrl.sv
// ============================================================================
// Module   : display_scan_ctrl
// Purpose  : Time-multiplexed 7-segment scan controller with double-buffered
//            digit values. Optional DISPLAY_BLANK_LZ_EN adds leading-zero blanking.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module display_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DIV        = 50000,
  parameter int DEAD       = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      load,
  output logic [3:0]                hex_digit,
  output logic [NUM_DIGITS-1:0]     digit_sel_n,
  output logic                      dp_n,
  output logic                      frame_done,
  output logic                      load_ack
);

  localparam int CW = $clog2(DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] C_DIV_M1   = CW'(DIV - 1);
  localparam logic [IW-1:0] C_LAST_IDX = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow_val;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic [4*NUM_DIGITS-1:0] r_disp_val;
  logic [NUM_DIGITS-1:0]   r_disp_dp;
  logic                    r_pending;
  logic                    r_frame_done;
  logic                    r_load_ack;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_dead_done;
  logic                    w_on;
  logic [NUM_DIGITS-1:0]   w_blank;

  assign w_slot_end  = (r_cnt == C_DIV_M1);
  assign w_frame_end = enable && w_slot_end && (r_idx == C_LAST_IDX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt        <= '0;
      r_idx        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_disp_val   <= '0;
      r_disp_dp    <= '0;
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
      r_load_ack   <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      r_load_ack   <= w_frame_end && r_pending;
      if (enable) begin
        if (w_slot_end) begin
          r_cnt <= '0;
          r_idx <= (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_frame_end && r_pending) begin
        r_disp_val <= r_shadow_val;
        r_disp_dp  <= r_shadow_dp;
        r_pending  <= 1'b0;
      end
      // A load on the transfer edge re-arms pending after the old shadow moves.
      if (load) begin
        r_shadow_val <= value;
        r_shadow_dp  <= dp;
        r_pending    <= 1'b1;
      end
    end
  end

  generate
    if (DEAD == 0) begin : g_no_dead
      assign w_dead_done = 1'b1;
    end else begin : g_dead
      localparam logic [CW-1:0] C_DEAD = CW'(DEAD);
      assign w_dead_done = (r_cnt >= C_DEAD);
    end
  endgenerate

`ifdef DISPLAY_BLANK_LZ_EN
  logic w_lz_run;

  // Scan from the most significant digit down; blank while the run of zeros holds.
  always_comb begin
    w_blank  = '0;
    w_lz_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      w_lz_run = w_lz_run && (r_disp_val[4*i +: 4] == 4'h0);
      if (i > 0) begin
        w_blank[i] = w_lz_run;
      end
    end
  end
`else
  assign w_blank = '0;
`endif

  assign w_on = enable && w_dead_done && !w_blank[r_idx];

  always_comb begin
    digit_sel_n = '1;
    dp_n        = 1'b1;
    if (w_on) begin
      digit_sel_n[r_idx] = 1'b0;
      dp_n               = ~r_disp_dp[r_idx];
    end
  end

  assign hex_digit  = r_disp_val[{r_idx, 2'b00} +: 4];
  assign frame_done = r_frame_done;
  assign load_ack   = r_load_ack;

endmodule

`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
// ============================================================================
// Module   : tb_display_scan_ctrl
// Purpose  : Directed, table-driven bench for display_scan_ctrl (4 digits, DIV=8, DEAD=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_display_scan_ctrl;

`ifdef DISPLAY_BLANK_LZ_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        load;
  logic [3:0]  hex_digit;
  logic [3:0]  digit_sel_n;
  logic        dp_n;
  logic        frame_done;
  logic        load_ack;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  display_scan_ctrl #(.NUM_DIGITS(4), .DIV(8), .DEAD(2)) dut (
    .clock       (clk),
    .reset       (reset),
    .enable      (enable),
    .value       (value),
    .dp          (dp),
    .load        (load),
    .hex_digit   (hex_digit),
    .digit_sel_n (digit_sel_n),
    .dp_n        (dp_n),
    .frame_done  (frame_done),
    .load_ack    (load_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [3:0] sel_n;
    logic [3:0] hex;
    logic       dpn;
    logic       fd;
    logic       ack;
  } vec_t;

  localparam int NV = 19;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b1;
    load   = 1'b0;
    value  = '0;
    dp     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    int p;
    int acks;
    int last_ack;
    int first_fd;

    vec[0]  = '{0,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[1]  = '{1,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[2]  = '{2,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[3]  = '{7,  4'b1110, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[4]  = '{8,  4'b1111, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[5]  = '{10, LZ ? 4'b1111 : 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{15, LZ ? 4'b1111 : 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[7]  = '{18, LZ ? 4'b1111 : 4'b1011, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[8]  = '{26, LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[9]  = '{31, LZ ? 4'b1111 : 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0};
    vec[10] = '{32, 4'b1111, 4'h4, 1'b1, 1'b1, 1'b1};
    vec[11] = '{33, 4'b1111, 4'h4, 1'b1, 1'b0, 1'b0};
    vec[12] = '{34, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b0};
    vec[13] = '{39, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b0};
    vec[14] = '{40, 4'b1111, 4'h3, 1'b1, 1'b0, 1'b0};
    vec[15] = '{41, 4'b1111, 4'h3, 1'b1, 1'b0, 1'b0};
    vec[16] = '{42, 4'b1101, 4'h3, 1'b0, 1'b0, 1'b0};
    vec[17] = '{47, 4'b1101, 4'h3, 1'b0, 1'b0, 1'b0};
    vec[18] = '{48, 4'b1111, 4'h2, 1'b1, 1'b0, 1'b0};

    // Basic scan plus a single load of 1234 with dp on digit 1
    do_reset();
    p = 0;
    for (int c = 0; c <= 48; c++) begin
      load  = (c == 5);
      value = 16'h1234;
      dp    = 4'b0010;
      #1;
      if (p < NV && vec[p].c == c) begin
        chk("sel_n", 16'(digit_sel_n), 16'(vec[p].sel_n));
        chk("hex",   16'(hex_digit),   16'(vec[p].hex));
        chk("dp_n",  16'(dp_n),        16'(vec[p].dpn));
        chk("frame_done", 16'(frame_done), 16'(vec[p].fd));
        chk("load_ack",   16'(load_ack),   16'(vec[p].ack));
        p++;
      end
      tick();
    end

    // Two loads before the transfer: last write wins, one ack
    do_reset();
    acks = 0; last_ack = -1;
    for (int c = 0; c <= 70; c++) begin
      load  = (c == 3) || (c == 9);
      value = (c == 3) ? 16'h1111 : 16'h2222;
      #1;
      if (load_ack) begin acks++; last_ack = c; end
      if (c == 40) chk("double_load_hex", 16'(hex_digit), 16'h2);
      tick();
    end
    chk("double_load_ack_count", 16'(acks), 16'd1);
    chk("double_load_ack_cycle", 16'(last_ack), 16'd32);

    // Load coinciding with the frame end
    do_reset();
    for (int c = 0; c <= 64; c++) begin
      load  = (c == 31);
      value = 16'hABCD;
      #1;
      if (c == 32) begin
        chk("edge_load_no_ack", 16'(load_ack), 16'd0);
        chk("edge_load_fd", 16'(frame_done), 16'd1);
      end
      if (c == 63) chk("edge_load_hex_old", 16'(hex_digit), 16'h0);
      if (c == 64) begin
        chk("edge_load_ack", 16'(load_ack), 16'd1);
        chk("edge_load_hex_new", 16'(hex_digit), 16'hD);
      end
      tick();
    end

    // Enable pause freezes scan and blanks display
    do_reset();
    first_fd = -1;
    for (int c = 0; c <= 45; c++) begin
      load   = 1'b0;
      enable = !(c >= 12 && c <= 20);
      #1;
      if (!enable) chk("pause_blank", 16'(digit_sel_n), 16'hF);
      if (c == 11) chk("pause_pre",  16'(digit_sel_n), LZ ? 16'hF : 16'hD);
      if (c == 21) chk("pause_resume", 16'(digit_sel_n), LZ ? 16'hF : 16'hD);
      if (c == 25) chk("pause_slot2_dead", 16'(digit_sel_n), 16'hF);
      if (c == 27) chk("pause_slot2", 16'(digit_sel_n), LZ ? 16'hF : 16'hB);
      if (frame_done && first_fd < 0) first_fd = c;
      tick();
    end
    chk("pause_frame_done_cycle", 16'(first_fd), 16'd41);
    enable = 1'b1;

    // Reset mid-frame with a pending load
    do_reset();
    for (int c = 0; c < 20; c++) begin
      load  = (c == 5);
      value = 16'h5678;
      dp    = 4'b1111;
      tick();
    end
    load  = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_sel_n", 16'(digit_sel_n), 16'hF);
    chk("rst_hex", 16'(hex_digit), 16'h0);
    chk("rst_dp_n", 16'(dp_n), 16'd1);
    chk("rst_fd", 16'(frame_done), 16'd0);
    chk("rst_ack", 16'(load_ack), 16'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc   = 0;
    acks  = 0;
    for (int c = 0; c <= 70; c++) begin
      #1;
      if (load_ack) acks++;
      if (c == 2) chk("rst_restart_sel", 16'(digit_sel_n), 16'hE);
      if (c == 70) chk("rst_hex_after", 16'(hex_digit), 16'h0);
      tick();
    end
    chk("rst_no_ack", 16'(acks), 16'd0);

    // Leading-zero handling with disp = 0030, then disp = 0
    do_reset();
    for (int c = 0; c <= 74; c++) begin
      load  = (c == 0) || (c == 40);
      value = (c == 0) ? 16'h0030 : 16'h0000;
      dp    = 4'b0000;
      #1;
      if (c == 34) chk("lz_d0", 16'(digit_sel_n), 16'hE);
      if (c == 42) begin
        chk("lz_d1", 16'(digit_sel_n), 16'hD);
        chk("lz_d1_hex", 16'(hex_digit), 16'h3);
      end
      if (c == 50) chk("lz_d2", 16'(digit_sel_n), LZ ? 16'hF : 16'hB);
      if (c == 58) chk("lz_d3", 16'(digit_sel_n), LZ ? 16'hF : 16'h7);
      if (c == 66) chk("lz_zero_d0", 16'(digit_sel_n), 16'hE);
      if (c == 74) chk("lz_zero_d1", 16'(digit_sel_n), LZ ? 16'hF : 16'hD);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexed scan controller for the board's multi-digit 7-segment display. It shares one hex-to-7-segment decoder and one set of segment pins among NUM_DIGITS digits. It drives the decoder's 4-bit input, the active-low digit anodes and the active-low decimal point. A shadow register double-buffers new values from the processor so that a digit never changes in the middle of a frame.

## Interface

Parameters:
- NUM_DIGITS, 4: number of digits scanned; legal range 1..8.
- DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- DEAD, 2: cycles at the start of each slot with all anodes off (anti-ghosting); 0 ≤ DEAD < DIV.

Ports:
- clock  in  1  — system clock; all state updates on the rising edge.
- reset  in  1  — asynchronous, active-high; clears all state.
- enable  in  1  — scan enable; low freezes the counters and blanks the display.
- value  in  4*NUM_DIGITS  — hex digits to show; digit i is value[4i+3:4i], digit 0 is rightmost.
- dp  in  NUM_DIGITS  — decimal point per digit, active-high; latched together with value.
- load  in  1  — single-cycle strobe that captures value/dp into the shadow register.
- hex_digit  out  4  — nibble fed to the shared decoder.
- digit_sel_n  out  NUM_DIGITS  — anodes, active-low, one-hot-low or all ones.
- dp_n  out  1  — decimal point, active-low.
- frame_done  out  1  — one-cycle pulse at the end of each frame.
- load_ack  out  1  — one-cycle pulse when the shadow contents are transferred to the display register.

## Operation

- State:
  - cnt: 0..DIV-1, slot prescaler.
  - idx: 0..NUM_DIGITS-1, current digit.
  - shadow and disp registers, each holding value and dp.
  - pending flag.
- When enable is high, on every cycle:
  - if cnt == DIV-1: cnt ← 0, idx ← idx+1, wrapping from NUM_DIGITS-1 to 0;
  - otherwise cnt ← cnt+1.
- When enable is low, cnt and idx hold their values.
- Frame end event: enable && cnt == DIV-1 && idx == NUM_DIGITS-1. On that edge:
  - frame_done ← 1 for the next cycle.
  - If pending: disp ← shadow, pending ← 0, and load_ack ← 1 for the next cycle.
- Load:
  - On the edge where load is high: shadow ← {value, dp}, pending ← 1.
  - A later load before the transfer overwrites shadow (last write wins); only one load_ack is issued.
  - If load coincides with the frame end event, the transfer uses the old shadow. The new value is captured and pending stays 1, so it is shown one frame later.
- Outputs are combinational decodes of the registers:
  - hex_digit = disp digit[idx].
  - digit_sel_n[i] = 0 iff enable && idx == i && cnt ≥ DEAD (and the digit is not blanked, see Configuration); otherwise 1.
  - dp_n = ~(disp.dp[idx] && the anode for idx is active).
- Reset values:
  - cnt = 0, idx = 0, shadow = 0, disp = 0, pending = 0.
  - hex_digit = 0, digit_sel_n = all ones, dp_n = 1, frame_done = 0, load_ack = 0.
- Reset mid-frame clears all state immediately. A pending load is discarded.

## Timing

- Slot length: DIV cycles. Frame length: NUM_DIGITS*DIV cycles.
- Anode i is low for DIV-DEAD consecutive cycles per frame.
- Latency from load to the value appearing on hex_digit: one frame end event, then the following slot 0. The worst case is just under 2 frames.
- frame_done and load_ack assert together, in the first cycle of the next frame's slot 0.
- Deasserting enable causes all anodes to go high combinationally in the same cycle. Reasserting enable resumes from the frozen cnt/idx.

## Configuration

- DISPLAY_BLANK_LZ_EN:
  - Defined: leading-zero blanking. Digit i > 0 keeps its anode high if disp digits i..NUM_DIGITS-1 are all zero. Digit 0 is always shown. dp_n is also suppressed on blanked digits. Slot timing is unchanged.
  - Undefined: every digit is shown.

## Test plan

All scenarios use NUM_DIGITS=4, DIV=8, DEAD=2, cycle 0 = first edge after reset release.

- Reset, enable=1, no load -> digit_sel_n=4'b1111 during cycles 0–1, 4'b1110 during cycles 2–7, 4'b1111 during 8–9, 4'b1101 during 10–15; hex_digit=0; frame_done high in cycle 32 only.
- load value=16'h1234, dp=4'b0010 at cycle 5 -> hex_digit stays 0 through cycle 31; load_ack=frame_done=1 in cycle 32. hex_digit=4 in cycles 32–39, 3 in 40–47. dp_n=0 only in cycles 42–47.
- Loads 16'h1111 at cycle 3 and 16'h2222 at cycle 9 -> single load_ack at cycle 32; hex_digit=2 afterwards.
- Load 16'hABCD exactly at cycle 31 -> no load_ack at 32 (pending was clear); load_ack at 64; hex_digit=D from cycle 64.
- enable=0 during cycles 12–20 -> digit_sel_n=4'b1111 throughout, cnt/idx frozen. Digit 1 slot resumes and ends 9 cycles late, so frame_done moves to cycle 41.
- reset pulse at cycle 20 with a load pending -> outputs at reset values immediately; no load_ack follows. With DISPLAY_BLANK_LZ_EN and disp=16'h0030: digits 2 and 3 are never selected; with disp=0 only digit 0 is selected.
